// File: rtl/rr_grant_ctrl_pkg.sv
// rr_grant_ctrl_pkg: shared sizes and state encoding for the grant controller
package rr_grant_ctrl_pkg;
  localparam int N = 8;
  localparam int IDXW = 3;
  localparam int CNTW = 16;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_grant_ctrl_pick.sv
// rr_pick: combinational rotating priority encoder, searching downward from start
module rr_pick
  import rr_grant_ctrl_pkg::*;
(
  input  logic [N-1:0]    vec,
  input  logic [IDXW-1:0] start,
  input  logic            mode,
  output logic            found,
  output logic [IDXW-1:0] idx
);
  logic [IDXW-1:0] base;
  assign base = mode ? start : IDXW'(N - 1);
  // Walk from lowest to highest priority so the highest-priority hit is written last
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[base - IDXW'(i)]) begin
        found = 1'b1;
        idx = base - IDXW'(i);
      end
    end
  end
endmodule

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: 8-way hold-until-release arbiter with optional hold timeout preemption
module rr_grant_ctrl
  import rr_grant_ctrl_pkg::*;
#(
  parameter int RR_MODE = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            preempt
);
  state_t          state;
  logic [CNTW-1:0] hold_cnt;
  logic [IDXW-1:0] last;
  logic [N-1:0]    mask;
  logic [N-1:0]    cand;
  logic [IDXW-1:0] start;
  logic [IDXW-1:0] w;
  logic            found;
  logic            timeout;
  logic            owner_req;

  assign cand = req & ~mask;
  assign start = last - IDXW'(1);
  assign owner_req = req[gnt_idx];
  assign timeout = (MAX_HOLD != 0) && (hold_cnt == CNTW'(MAX_HOLD - 1)) && (|(req & ~gnt));

  rr_pick u_pick (
    .vec  (cand),
    .start(start),
    .mode (RR_MODE != 0),
    .found(found),
    .idx  (w)
  );

  // Arbitration FSM: grant from IDLE, release on owner drop or contended timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      gnt_idx <= '0;
      gnt_valid <= 1'b0;
      preempt <= 1'b0;
      hold_cnt <= '0;
      last <= '0;
      mask <= '0;
    end else if (state == IDLE) begin
      preempt <= 1'b0;
      if (found) begin
        state <= GRANT;
        gnt <= N'(1) << w;
        gnt_idx <= w;
        gnt_valid <= 1'b1;
        hold_cnt <= '0;
        last <= w;
        mask <= '0;
      end else if (|req) begin
        mask <= '0;
      end
    end else begin
      hold_cnt <= (&hold_cnt) ? hold_cnt : hold_cnt + CNTW'(1);
      if (!owner_req || timeout) begin
        state <= IDLE;
        gnt <= '0;
        gnt_idx <= '0;
        gnt_valid <= 1'b0;
        preempt <= owner_req;
        mask <= owner_req ? gnt : '0;
      end
    end
  end

  // Grant vector must be one-hot or zero and agree with the encoded index
  always_ff @(posedge clk) begin
    if (rst_n) assert ($onehot0(gnt) && (gnt == (gnt_valid ? N'(1) << gnt_idx : '0)));
  end
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb_rr_grant_ctrl: directed checks of fixed, round-robin, timeout and reset behaviour
module tb_rr_grant_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gf, gr;
  logic [2:0] xf, xr;
  logic       vf, vr, pf, pr;
  int cmps = 0;
  int errs = 0;

  always #5 clk = ~clk;

  rr_grant_ctrl #(.RR_MODE(0), .MAX_HOLD(16)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gf), .gnt_idx(xf), .gnt_valid(vf), .preempt(pf)
  );

  rr_grant_ctrl #(.RR_MODE(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gr), .gnt_idx(xr), .gnt_valid(vr), .preempt(pr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 8'h00;
    tick(1);
    rst_n = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_gf", gf, 8'h00);
    chk("rst_vf", vf, 0);
    chk("rst_xf", xf, 0);
    chk("rst_pf", pf, 0);
    chk("rst_gr", gr, 8'h00);
    chk("rst_vr", vr, 0);
    chk("rst_xr", xr, 0);
    chk("rst_pr", pr, 0);
    tick(1);
    rst_n = 1'b1;
    req = 8'h20;
    tick(1);
    chk("mid_gf", gf, 8'h20);
    chk("mid_gr", gr, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gf", gf, 8'h00);
    chk("async_vf", vf, 0);
    chk("async_gr", gr, 8'h00);
    chk("async_vr", vr, 0);
    tick(1);
    rst_n = 1'b1;
    req = 8'h21;
    tick(1);
    chk("after_rst_gf", gf, 8'h20);
    chk("after_rst_xf", xf, 5);
    chk("after_rst_gr", gr, 8'h20);
    do_reset();
    req = 8'h26;
    tick(1);
    chk("fix_g1", gf, 8'h20);
    chk("fix_x1", xf, 5);
    chk("fix_v1", vf, 1);
    req = 8'h06;
    tick(1);
    chk("fix_dead_g", gf, 8'h00);
    chk("fix_dead_v", vf, 0);
    tick(1);
    chk("fix_g2", gf, 8'h04);
    chk("fix_x2", xf, 2);
    do_reset();
    req = 8'hFF;
    for (int k = 15; k >= 7; k--) begin
      tick(1);
      chk("rr_g", gr, 32'(8'h01 << (k % 8)));
      chk("rr_x", xr, k % 8);
      tick(1);
      chk("rr_hold", gr, 32'(8'h01 << (k % 8)));
      req = 8'hFF & ~(8'h01 << (k % 8));
      tick(1);
      chk("rr_dead", vr, 0);
      req = 8'hFF;
    end
    do_reset();
    req = 8'h81;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      chk("to_own7", gr, 8'h80);
      chk("to_nopre", pr, 0);
    end
    tick(1);
    chk("to_rel_g", gr, 8'h00);
    chk("to_pre", pr, 1);
    tick(1);
    chk("to_mask_g", gr, 8'h01);
    chk("to_mask_p", pr, 0);
    tick(4);
    chk("to_rel2_p", pr, 1);
    tick(1);
    chk("to_back7", gr, 8'h80);
    do_reset();
    req = 8'h08;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      chk("solo_g", gr, 8'h08);
      chk("solo_p", pr, 0);
    end
    do_reset();
    req = 8'h12;
    tick(1);
    chk("sim_g4", gr, 8'h10);
    tick(3);
    req = 8'h02;
    tick(1);
    chk("sim_rel_g", gr, 8'h00);
    chk("sim_rel_p", pr, 0);
    tick(1);
    chk("sim_g1", gr, 8'h02);
    chk("sim_x1", xr, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
